// File: rtl/comp_capture_pretrig.sv
// Pre-trigger packet capture for comparator frames: PRE-frame history, L-frame packets
// written whole into a single-clock FIFO, with holdoff, overflow dropping and PRBS error counting.
module comp_capture_pretrig #(
  parameter int DW      = 48,
  parameter int PRE     = 3,
  parameter int POST    = 5,
  parameter int AW      = 8,
  parameter int HOLDOFF = 4,
  parameter int CW      = 16
) (
  input  logic          rx_clk,
  input  logic          reset_n,
  input  logic          word0,
  input  logic [DW-1:0] comp_dat,
  input  logic          rx_valid,
  input  logic          rx_match,
  input  logic          ext_trig,
  input  logic [1:0]    trig_mode,
  input  logic          flush,
  input  logic          en_prbs,
  input  logic          rst_errcount,
  input  logic          rd_en,
  output logic [DW+1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          overflow,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] drop_count,
  output logic [CW-1:0] pkt_count
);

  localparam int L     = PRE + 1 + POST;
  localparam int DEPTH = 1 << AW;
  localparam int WCW   = $clog2(L + 1);
  localparam int HCW   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HOLDOFF} state_t;

  state_t          state, state_next;
  logic [WCW-1:0]  wcnt, wcnt_next;
  logic [HCW-1:0]  hcnt, hcnt_next;
  logic [AW:0]     wr_ptr, rd_ptr, occupancy;
  logic [DW+1:0]   mem [DEPTH];
  logic [DW-1:0]   tap;
  logic            trig, has_room, rd_ok;
  logic            wr_en, wr_sop, wr_eop, pkt_done, drop;

  // tap is the frame PRE word0s old; history starts out as zeros
  generate
    if (PRE == 0) begin : g_nohist
      assign tap = comp_dat;
    end else begin : g_hist
      logic [DW-1:0] hist [PRE];
      always_ff @(posedge rx_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PRE; i++) hist[i] <= '0;
        end else if (word0) begin
          hist[0] <= comp_dat;
          for (int i = 1; i < PRE; i++) hist[i] <= hist[i-1];
        end
      end
      assign tap = hist[PRE-1];
    end
  endgenerate

  assign trig      = (trig_mode[0] & (|comp_dat)) | (trig_mode[1] & ext_trig);
  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (occupancy == '0);
  assign has_room  = (DEPTH - int'(occupancy)) >= L;
  assign rd_ok     = rd_en & ~empty & ~flush;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    hcnt_next  = hcnt;
    wr_en      = 1'b0;
    wr_sop     = 1'b0;
    wr_eop     = 1'b0;
    pkt_done   = 1'b0;
    drop       = 1'b0;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (word0 && trig) begin
            if (has_room) begin
              // the trigger frame itself carries the first (sop) write
              wr_en  = 1'b1;
              wr_sop = 1'b1;
              if (L == 1) begin
                wr_eop     = 1'b1;
                pkt_done   = 1'b1;
                state_next = S_HOLDOFF;
                hcnt_next  = HCW'(HOLDOFF);
              end else begin
                state_next = S_CAPTURE;
                wcnt_next  = WCW'(L - 1);
              end
            end else begin
              drop       = 1'b1;
              state_next = S_HOLDOFF;
              hcnt_next  = HCW'(HOLDOFF);
            end
          end
        end
        S_CAPTURE: begin
          if (word0) begin
            wr_en     = 1'b1;
            wcnt_next = wcnt - 1'b1;
            if (wcnt == WCW'(1)) begin
              wr_eop     = 1'b1;
              pkt_done   = 1'b1;
              state_next = S_HOLDOFF;
              hcnt_next  = HCW'(HOLDOFF);
            end
          end
        end
        S_HOLDOFF: begin
          if (hcnt == '0) begin
            state_next = S_IDLE;
          end else if (word0) begin
            hcnt_next = hcnt - 1'b1;
            if (hcnt == HCW'(1)) state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {wr_sop, wr_eop, tap};
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      hcnt       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      pkt_count  <= '0;
    end else begin
      state      <= state_next;
      wcnt       <= wcnt_next;
      hcnt       <= hcnt_next;
      dout_valid <= rd_ok;
      if (rd_ok) dout <= mem[rd_ptr[AW-1:0]];
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
        if (drop)  overflow <= 1'b1;
      end
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
      if (pkt_done) pkt_count <= pkt_count + 1'b1;
    end
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (rst_errcount) begin
      err       <= 1'b0;
      err_count <= '0;
    end else if (word0) begin
      err <= en_prbs & rx_valid & ~rx_match;
      if (en_prbs && rx_valid && !rx_match && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_comp_capture_pretrig.sv
// Bench for comp_capture_pretrig: packet capture/drop/holdoff/flush/reset scenarios against a
// scoreboard of expected FIFO entries, plus a table of PRBS error-counting vectors.
module tb_comp_capture_pretrig;

  localparam int DW = 16;
  localparam int PRE = 3;
  localparam int POST = 5;
  localparam int L = PRE + 1 + POST;
  localparam int CW = 8;

  logic          rx_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          word0 = 1'b0;
  logic [DW-1:0] comp_dat = '0;
  logic          rx_valid = 1'b0;
  logic          rx_match = 1'b0;
  logic          ext_trig = 1'b0;
  logic [1:0]    trig_mode = 2'd0;
  logic          flush = 1'b0;
  logic          en_prbs = 1'b0;
  logic          rst_errcount = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW+1:0] dout;
  logic          dout_valid, empty, overflow, busy, err;
  logic [CW-1:0] err_count, drop_count, pkt_count;

  comp_capture_pretrig #(
    .DW(DW), .PRE(PRE), .POST(POST), .AW(4), .HOLDOFF(4), .CW(CW)
  ) dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .word0(word0), .comp_dat(comp_dat),
    .rx_valid(rx_valid), .rx_match(rx_match), .ext_trig(ext_trig), .trig_mode(trig_mode),
    .flush(flush), .en_prbs(en_prbs), .rst_errcount(rst_errcount), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .empty(empty), .overflow(overflow), .busy(busy),
    .err(err), .err_count(err_count), .drop_count(drop_count), .pkt_count(pkt_count)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic       en;
    logic       valid;
    logic       match;
    logic       rst;
    logic       exp_err;
    logic [7:0] exp_cnt;
  } prbs_vec_t;

  int checks = 0;
  int errors = 0;
  int fn = 0;
  logic [DW-1:0] fd [0:63];
  logic [DW+1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge rx_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge rx_clk);
    reset_n = 1'b1;
    fn = 0;
  endtask

  // one frame = 4 clocks with word0 on the first
  task automatic send_frame(input logic [DW-1:0] d, input logic ext);
    @(negedge rx_clk);
    word0 = 1'b1;
    comp_dat = d;
    ext_trig = ext;
    fd[fn] = d;
    fn++;
    @(negedge rx_clk);
    word0 = 1'b0;
    ext_trig = 1'b0;
    repeat (2) @(negedge rx_clk);
  endtask

  // expected packet for a trigger at frame t: frames t-PRE .. t+POST, pre-reset history is zero
  task automatic push_pkt(input int t);
    for (int k = 0; k < L; k++) begin
      int idx;
      logic [DW-1:0] d;
      idx = t - PRE + k;
      d = (idx < 0) ? '0 : fd[idx];
      exp_q.push_back({(k == 0), (k == L - 1), d});
    end
  endtask

  task automatic drain(input string name);
    int n;
    logic [DW+1:0] e;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge rx_clk);
      rd_en = 1'b1;
      @(negedge rx_clk);
      rd_en = 1'b0;
      check($sformatf("%s pop%0d valid", name, n), 64'(dout_valid), 64'd1);
      check($sformatf("%s pop%0d dout", name, n), 64'(dout), 64'(e));
      n++;
    end
    @(negedge rx_clk);
    check($sformatf("%s empty", name), 64'(empty), 64'd1);
  endtask

  prbs_vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

    // reset state
    do_reset();
    @(negedge rx_clk);
    check("rst dout", 64'(dout), 64'd0);
    check("rst dout_valid", 64'(dout_valid), 64'd0);
    check("rst empty", 64'(empty), 64'd1);
    check("rst overflow", 64'(overflow), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst counts", {40'd0, err_count, drop_count, pkt_count}, 64'd0);

    // nonzero trigger at frame 10 -> frames 7..15
    trig_mode = 2'd1;
    for (int n = 0; n < 25; n++)
      send_frame((n < 10) ? 16'h0 : (n == 10) ? 16'h1 : (n <= 22) ? 16'hA000 + 16'(n) : 16'h0, 1'b0);
    push_pkt(10);
    check("t1 pkt_count", 64'(pkt_count), 64'd1);
    check("t1 busy", 64'(busy), 64'd0);
    drain("t1");

    // trigger on first frame after reset, small FIFO overflows on second trigger
    do_reset();
    trig_mode = 2'd1;
    for (int n = 0; n < 14; n++) send_frame(16'h200 + 16'(n), 1'b0);
    push_pkt(0);
    check("t3 pkt_count", 64'(pkt_count), 64'd1);
    check("t3 drop_count", 64'(drop_count), 64'd1);
    check("t3 overflow", 64'(overflow), 64'd1);
    check("t3 busy", 64'(busy), 64'd1);
    drain("t3");
    @(negedge rx_clk);
    flush = 1'b1;
    @(negedge rx_clk);
    flush = 1'b0;
    check("t3 overflow after flush", 64'(overflow), 64'd0);
    check("t3 drop_count kept", 64'(drop_count), 64'd1);

    // continuous triggers: packets at frames 0 and 13 only
    do_reset();
    trig_mode = 2'd3;
    for (int n = 0; n < 13; n++) send_frame(16'h300 + 16'(n), 1'b0);
    push_pkt(0);
    drain("t4a");
    for (int n = 13; n < 28; n++) send_frame((n <= 20) ? 16'h300 + 16'(n) : 16'h0, 1'b0);
    push_pkt(13);
    drain("t4b");
    check("t4 pkt_count", 64'(pkt_count), 64'd2);
    check("t4 drop_count", 64'(drop_count), 64'd0);

    // PRBS vectors with trig_mode 0 and nonzero data: never captures
    do_reset();
    trig_mode = 2'd0;
    for (int i = 0; i < 9; i++) begin
      en_prbs = tbl[i].en;
      rx_valid = tbl[i].valid;
      rx_match = tbl[i].match;
      rst_errcount = tbl[i].rst;
      send_frame(16'hFFFF, 1'b1);
      rst_errcount = 1'b0;
      check($sformatf("prbs%0d err", i), 64'(err), 64'(tbl[i].exp_err));
      check($sformatf("prbs%0d count", i), 64'(err_count), 64'(tbl[i].exp_cnt));
    end
    en_prbs = 1'b1;
    rx_valid = 1'b1;
    rx_match = 1'b0;
    for (int i = 0; i < 300; i++) send_frame(16'h5, 1'b1);
    check("prbs saturate", 64'(err_count), 64'hFF);
    check("mode0 busy", 64'(busy), 64'd0);
    check("mode0 empty", 64'(empty), 64'd1);
    en_prbs = 1'b0;
    @(negedge rx_clk);
    rst_errcount = 1'b1;
    @(negedge rx_clk);
    rst_errcount = 1'b0;
    check("prbs clear", 64'(err_count), 64'd0);
    rx_valid = 1'b0;

    // flush mid-capture, history survives the flush
    do_reset();
    trig_mode = 2'd2;
    for (int n = 0; n < 5; n++) send_frame(16'h600 + 16'(n), (n == 2));
    check("t6 busy mid", 64'(busy), 64'd1);
    check("t6 not empty mid", 64'(empty), 64'd0);
    @(negedge rx_clk);
    flush = 1'b1;
    rd_en = 1'b1;
    @(negedge rx_clk);
    flush = 1'b0;
    rd_en = 1'b0;
    check("t6 flush empty", 64'(empty), 64'd1);
    check("t6 flush busy", 64'(busy), 64'd0);
    check("t6 flush beats rd", 64'(dout_valid), 64'd0);
    @(negedge rx_clk);
    rd_en = 1'b1;
    @(negedge rx_clk);
    rd_en = 1'b0;
    check("t6 pop empty ignored", 64'(dout_valid), 64'd0);
    for (int n = 5; n < 17; n++) send_frame(16'h600 + 16'(n), (n == 8));
    push_pkt(8);
    check("t6 pkt_count", 64'(pkt_count), 64'd1);
    drain("t6");

    // asynchronous reset mid-capture
    for (int n = 17; n < 24; n++) send_frame(16'h600 + 16'(n), (n == 21));
    check("t6r busy before", 64'(busy), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check("t6r empty", 64'(empty), 64'd1);
    check("t6r busy", 64'(busy), 64'd0);
    check("t6r pkt_count", 64'(pkt_count), 64'd0);
    @(negedge rx_clk);
    reset_n = 1'b1;
    fn = 0;
    for (int n = 0; n < 12; n++) send_frame(16'h0, 1'b0);
    check("t6r still empty", 64'(empty), 64'd1);
    check("t6r still idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
